// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, lock FSM states and registered output bundle.
// Values only; no logic, no latency, no backpressure.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_DEF  = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_ACTIVE_DEF  = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;
  localparam int LOCK_WAIT_DEF = 1024;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Inclusive sync windows: hsync low for h in [656,751], vsync low for v in [490,491].
  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } lock_state_e;

  typedef struct packed {
    logic             hsync;
    logic             vsync;
    logic             blank_n;
    logic             line_start;
    logic             frame_start;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } vga_out_t;

  localparam vga_out_t VGA_IDLE = '{
    hsync:       1'b1,
    vsync:       1'b1,
    blank_n:     1'b0,
    line_start:  1'b0,
    frame_start: 1'b0,
    x:           '0,
    y:           '0
  };

  function automatic logic in_window(input logic [CNT_W-1:0] val,
                                     input int lo, input int hi);
    return (int'(val) >= lo) && (int'(val) <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_lock_qualifier.sv
// Synchronises pll_locked and holds the raster off until lock has been stable LOCK_WAIT clocks.
// running_o rises LOCK_WAIT+1 clocks after synchronised lock; no backpressure.
module lock_qualifier
  import vga_timing_pkg::*;
#(
  parameter int LOCK_WAIT = LOCK_WAIT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pll_locked_i,
  output logic advance_o,
  output logic running_o
);

  localparam int LW_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [LW_W-1:0] LW_LAST = LW_W'(LOCK_WAIT - 1);

  logic            meta_q;
  logic            lock_s_q;
  lock_state_e     state_q, state_d;
  logic [LW_W-1:0] cnt_q, cnt_d;

  // pll_locked comes from another clock domain; two flops before any decision.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q   <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      meta_q   <= pll_locked_i;
      lock_s_q <= meta_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s_q) state_d = SETTLE;
      end
      SETTLE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LW_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + LW_W'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s_q) state_d = WAIT_LOCK;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Losing lock in RUN must idle the outputs on the same edge the FSM leaves RUN.
  assign advance_o = (state_q == RUN) && lock_s_q;
  assign running_o = (state_q == RUN);

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator gated by a qualified PLL lock.
// Outputs registered one clock after the h/v count; free-running, no backpressure.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int LOCK_WAIT = LOCK_WAIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             hsync,
  output logic             vsync,
  output logic             blank_n,
  output logic             sync_n,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
  output logic             running
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);

  logic             advance;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  vga_out_t         out_q, out_d;

  lock_qualifier #(
    .LOCK_WAIT (LOCK_WAIT)
  ) u_lock_qualifier (
    .clk_i        (clk),
    .rst_i        (rst),
    .pll_locked_i (pll_locked),
    .advance_o    (advance),
    .running_o    (running)
  );

  // Counters sit at 0 outside RUN, so the edge entering RUN naturally loads h=0, v=0.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!advance) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
    end else begin
      h_d = h_q + CNT_W'(1);
    end
  end

  always_comb begin
    out_d = VGA_IDLE;
    if (advance) begin
      out_d.blank_n     = (h_q < H_ACT) && (v_q < V_ACT);
      out_d.hsync       = !in_window(h_q, HS_START, HS_END);
      out_d.vsync       = !in_window(v_q, VS_START, VS_END);
      out_d.x           = (h_q < H_ACT) ? h_q : '0;
      out_d.y           = (v_q < V_ACT) ? v_q : '0;
      out_d.line_start  = (h_q == '0);
      out_d.frame_start = (h_q == '0) && (v_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q   <= '0;
      v_q   <= '0;
      out_q <= VGA_IDLE;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      out_q <= out_d;
    end
  end

  assign hsync       = out_q.hsync;
  assign vsync       = out_q.vsync;
  assign blank_n     = out_q.blank_n;
  assign x           = out_q.x;
  assign y           = out_q.y;
  assign line_start  = out_q.line_start;
  assign frame_start = out_q.frame_start;
  assign sync_n      = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a scaled-down raster (30x19 clocks, LOCK_WAIT=16).
// Per-cycle comparison against a lock-streak model plus directed timing checks.
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 4, HS = 6, HBP = 4;
  localparam int VA = 12, VFP = 2, VS = 2, VBP = 3;
  localparam int LW = 16;
  localparam int HT = HA + HFP + HS + HBP;   // 30
  localparam int VT = VA + VFP + VS + VBP;   // 19

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       hsync, vsync, blank_n, sync_n, line_start, frame_start, running;
  logic [9:0] x, y;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .LOCK_WAIT (LW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .sync_n      (sync_n),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start),
    .running     (running)
  );

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Model: count consecutive edges on which the synchronised lock was high.
  // Streak LW+1 means RUN with idle outputs; from LW+2 on the raster time is streak-(LW+2).
  bit m_s1, m_s2;
  int streak = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_s1   = 1'b0;
      m_s2   = 1'b0;
      streak = 0;
    end else begin
      if (m_s2) streak++;
      else      streak = 0;
      m_s2 = m_s1;
      m_s1 = pll_locked;
    end
  end

  function automatic logic [26:0] expect_vec(input int s);
    int t, h, v;
    logic run, hs, vs, bn, ls, fs;
    logic [9:0] ex, ey;
    run = (s >= LW + 1);
    hs = 1'b1; vs = 1'b1; bn = 1'b0; ls = 1'b0; fs = 1'b0; ex = '0; ey = '0;
    if (s >= LW + 2) begin
      t  = s - (LW + 2);
      h  = t % HT;
      v  = (t / HT) % VT;
      bn = (h < HA) && (v < VA);
      hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
      vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
      ls = (h == 0);
      fs = (h == 0) && (v == 0);
      ex = (h < HA) ? 10'(h) : 10'd0;
      ey = (v < VA) ? 10'(v) : 10'd0;
    end
    return {run, hs, vs, bn, 1'b0, ls, fs, ex, ey};
  endfunction

  always begin
    step();
    if (chk_en)
      check("outputs", int'({running, hsync, vsync, blank_n, sync_n, line_start,
                             frame_start, x, y}), int'(expect_vec(streak)));
  end

  // Counts edges until frame_start is seen, bounded so a dead DUT cannot hang the run.
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_start && n < 2000);
    if (!frame_start) check("frame_start_timeout", 0, 1);
  endtask

  initial begin
    int n, act, hl, vl, lsn, fsn, first_hl, first_vl, prev_ls, line_gap;
    logic [15:0] seen_x;
    logic [11:0] seen_y;

    // Reset with lock already high.
    rst = 1'b1;
    pll_locked = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    step();
    check("reset_running", running, 0);
    check("reset_syncs", int'({hsync, vsync}), 3);
    check("reset_blank_n", blank_n, 0);
    check("reset_strobes", int'({line_start, frame_start}), 0);
    check("reset_xy", int'({x, y}), 0);

    rst = 1'b0;
    wait_frame(n);
    check("lock_to_frame_latency", n, LW + 4);
    check("first_xy", int'({x, y}), 0);
    check("first_blank_n", blank_n, 1);
    check("first_line_start", line_start, 1);

    // Two full frames of raster statistics, each measured from its frame_start sample.
    for (int f = 0; f < 2; f++) begin
      act = 0; hl = 0; vl = 0; lsn = 0; fsn = 0;
      first_hl = -1; first_vl = -1; prev_ls = -1; line_gap = -1;
      seen_x = '0; seen_y = '0;
      for (int i = 0; i < HT * VT; i++) begin
        if (i > 0) step();
        if (blank_n) begin
          act++;
          if (x < HA && y < VA) begin
            seen_x[x[3:0]] = 1'b1;
            seen_y[y[3:0]] = 1'b1;
          end
        end
        if (!hsync) begin
          hl++;
          if (first_hl < 0) first_hl = i;
        end
        if (!vsync) begin
          vl++;
          if (first_vl < 0) first_vl = i;
        end
        if (line_start) begin
          lsn++;
          if (prev_ls >= 0 && line_gap < 0) line_gap = i - prev_ls;
          prev_ls = i;
        end
        if (frame_start) fsn++;
      end
      check("active_clocks", act, 192);
      check("hsync_low_clocks", hl, 114);
      check("hsync_first_low_h", first_hl, 20);
      check("vsync_low_clocks", vl, 60);
      check("vsync_first_low_clock", first_vl, 420);
      check("line_starts", lsn, 19);
      check("line_period", line_gap, 30);
      check("frame_starts", fsn, 1);
      check("x_coverage", int'(seen_x), 'hFFFF);
      check("y_coverage", int'(seen_y), 'hFFF);
      step();
      check("frame_period_570", frame_start, 1);
    end

    // Lock loss mid-frame at h=7, v=5.
    n = 0;
    do begin
      step();
      n++;
    end while (!(blank_n && x == 7 && y == 5) && n < 1000);
    check("reach_h7_v5", n, 157);
    pll_locked = 1'b0;
    step();
    check("drop_running_1", running, 1);
    step();
    check("drop_running_2", running, 1);
    step();
    check("drop_running_3", running, 0);
    check("drop_syncs", int'({hsync, vsync}), 3);
    check("drop_blank_n", blank_n, 0);
    pll_locked = 1'b1;
    wait_frame(n);
    check("relock_latency", n, LW + 4);

    // One-clock lock glitch while SETTLE's counter is at 8.
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (9) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    wait_frame(n);
    check("glitch_latency", n + 10, 30);

    // Reset in RUN just before the hsync window opens.
    repeat (HT) step();
    check("pre_rst_line_start", line_start, 1);
    repeat (HA + HFP - 1) step();
    check("pre_rst_hsync_high", hsync, 1);
    rst = 1'b1;
    hl = 0;
    step();
    check("rst_running", running, 0);
    check("rst_outputs", int'({hsync, vsync, blank_n, line_start, frame_start, x, y}),
          int'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0}));
    for (int i = 0; i < 8; i++) begin
      if (!hsync) hl++;
      if (i == 4) rst = 1'b0;
      step();
    end
    check("rst_hsync_never_low", hl, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
